rx_buf_ctrl: RTL and testbench
==============================

// Module: rx_buf_ctrl
// PURPOSE
//  Ping-pong write controller for the 1 KiB RX payload SRAM (port 0), clocked by RX_CLK.
//  - Splits the SRAM into two 512-byte slots.
//  - Steers each UDP payload from rx_udp into the next free slot and records its length.
//  - Raises a one-cycle frame interrupt when a frame is complete.
//  - Drops frames when no slot is free, when a frame overflows its slot, or when a frame is flagged bad.
//  - The host frees slots through slot_release; the Wishbone side reads the SRAM on port 1.
// PARAMETERS
//  ADDR_W   10   SRAM address width (1024 bytes)
//  SLOT_W    9   slot offset width; slot size = 2**SLOT_W bytes; slot index = addr[ADDR_W-1]
//  LEN_W    10   length field width; holds 0..2**SLOT_W
// PORTS
//  RX_CLK         in   1        clock
//  rst            in   1        synchronous reset, active-high
//  rx_data_v      in   1        payload byte valid (from rx_udp); frame = contiguous high run
//  rx_data        in   8        payload byte
//  rx_frame_err   in   1        sampled any cycle of a frame; marks that frame bad
//  slot_release   in   2        one-cycle pulse per slot; host has consumed the slot (already RX_CLK-synchronous)
//  mem_csb0       out  1        SRAM port-0 chip select, active low
//  mem_web0       out  1        SRAM port-0 write enable, active low
//  mem_addr0      out  ADDR_W   SRAM port-0 address {slot, offset}
//  mem_din0       out  8        SRAM port-0 write data
//  slot_full      out  2        slot holds a committed, unreleased frame
//  slot_len0      out  LEN_W    byte count of slot 0 (valid while slot_full[0])
//  slot_len1      out  LEN_W    byte count of slot 1
//  head_slot      out  1        oldest full slot (the one the host reads next)
//  frame_irq      out  1        one-cycle pulse on every commit
// BEHAVIOUR
//  Reset: state=IDLE; wr_slot=0; head_slot=0; slot_full=0; slot_len*=0; frame_irq=0;
//    mem_csb0=1; mem_web0=1; mem_addr0=0; mem_din0=0.
//  Memory outputs are registered: a byte presented in cycle N is driven to the SRAM in cycle N+1.
//    - csb0 and web0 are driven low together, for exactly one cycle per accepted byte.
//  FSM:
//    IDLE:    if rx_data_v and !slot_full[wr_slot] -> WRITE; write byte at offset 0; offset=1.
//             if rx_data_v and the slot is full    -> DISCARD.
//    WRITE:   each rx_data_v cycle writes at {wr_slot, offset} and increments offset.
//             A byte arriving when offset==2**SLOT_W (slot already full of bytes) -> DISCARD; that byte is not written.
//             rx_data_v low: if err_seen -> IDLE (drop, nothing committed); else -> COMMIT.
//    COMMIT:  (1 cycle) slot_full[wr_slot]<=1; slot_len<=offset; frame_irq<=1; wr_slot<=~wr_slot; -> IDLE.
//    DISCARD: wait for rx_data_v low -> IDLE; no state is changed except the drop counter.
//  err_seen is set by rx_frame_err in any cycle from frame start to end, and cleared on entry to IDLE.
//  Bytes already written by a dropped frame remain in the SRAM but are never flagged; the slot stays free.
//  Back-to-back frames: a new rx_data_v rise in the COMMIT cycle is treated as an IDLE entry on the next cycle.
//    Upstream guarantees at least 1 idle cycle between frames.
//  Release:
//    - slot_release[i] clears slot_full[i] only if that slot is full; otherwise it is ignored.
//    - A release coinciding with a COMMIT to the other slot: both take effect in the same cycle.
//    - A release of head_slot flips head_slot.
//  head_slot update: tracks commit order. A commit into an empty controller sets head_slot to the committed slot.
//  Reset asserted mid-frame: everything returns to reset values at once; the remainder of the frame is then seen as a new frame.
// CONFIGURATION
//  RX_BUF_DROP_CNT_EN defined:
//    - adds output drop_cnt [15:0].
//    - Increments by 1 per dropped frame (no slot free, overflow, or rx_frame_err). Saturates at 16'hFFFF; reset 0.
//    - A drop is counted on the exit from DISCARD, or on the WRITE->IDLE exit when err_seen is set.
//  RX_BUF_DROP_CNT_EN undefined: no port, no counter logic.
// STRUCTURE
//  Shared package vthernet_pkg: FSM state encoding (IDLE/WRITE/COMMIT/DISCARD) and the slot-geometry constants
//    ADDR_W, SLOT_W, LEN_W.
//  Single module; no sub-module. The slot-state bookkeeping (full bits, lengths, head) stays inline.
// TESTING
//  1. 64-byte frame 0x00..0x3F, slots empty -> addr 0x000..0x03F written; slot_full=01; slot_len0=64;
//     one frame_irq; head_slot=0.
//  2. Two frames of 10 and 20 bytes, no release -> slot_len0=10, slot_len1=20, slot_full=11;
//     a third frame writes nothing; drop_cnt=1 if enabled.
//  3. 513-byte frame into an empty slot -> 512 writes, no commit, no irq; slot_full unchanged; drop_cnt +1.
//  4. 30-byte frame with rx_frame_err pulsed at byte 15 -> no commit; the next frame reuses the same slot at addr 0x000.
//  5. Both slots full, slot_release=01 -> slot_full=10, head_slot=1; next frame lands in slot 0 (addr 0x000).
//     slot_release=01 in the same cycle as a commit to slot 1 -> both take effect.
//  6. rst asserted at byte 100 of a frame -> all outputs return to reset values the next cycle; mem_csb0=1.

Source files
------------

// File: rtl/vthernet_pkg.sv
// Shared Vthernet definitions: RX payload buffer geometry and the write-controller state encoding.
package vthernet_pkg;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned SLOT_W     = 9;
    localparam int unsigned LEN_W      = 10;
    localparam int unsigned SLOT_BYTES = 1 << SLOT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_COMMIT,
        ST_DISCARD
    } rx_state_e;

    // One SRAM port-0 write beat
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } mem_wr_t;

endpackage

// File: rtl/rx_buf_ctrl_if.sv
// RX payload stream from rx_udp plus SRAM port-0 write bus of the RX buffer controller.
interface rx_buf_ctrl_if;
    import vthernet_pkg::*;

    logic              rx_data_v;
    logic [7:0]        rx_data;
    logic              rx_frame_err;
    logic              mem_csb0;
    logic              mem_web0;
    logic [ADDR_W-1:0] mem_addr0;
    logic [7:0]        mem_din0;

    modport master (
        output rx_data_v, rx_data, rx_frame_err,
        input  mem_csb0, mem_web0, mem_addr0, mem_din0
    );

    modport slave (
        input  rx_data_v, rx_data, rx_frame_err,
        output mem_csb0, mem_web0, mem_addr0, mem_din0
    );
endinterface

// File: rtl/rx_buf_ctrl.sv
// Ping-pong write controller steering UDP payloads into two 512-byte SRAM slots.
// Optional drop counter output drop_cnt is built when RX_BUF_DROP_CNT_EN is defined.
module rx_buf_ctrl
    import vthernet_pkg::*;
(
    input  logic             RX_CLK,
    input  logic             rst,
    rx_buf_ctrl_if.slave     rx,
    input  logic [1:0]       slot_release,
    output logic [1:0]       slot_full,
    output logic [LEN_W-1:0] slot_len0,
    output logic [LEN_W-1:0] slot_len1,
    output logic             head_slot,
    output logic             frame_irq
`ifdef RX_BUF_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    rx_state_e        state_q, state_d;
    logic             wr_slot;
    logic             nxt_slot;
    logic [LEN_W-1:0] offset_q, offset_d;
    logic             err_seen, err_d;
    logic             offset_full;
    logic             wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic             commit;
    logic             drop;
    logic [1:0]       full_after_rel;
    logic [1:0]       full_d;
    logic             head_d;
    logic             csb_q;
    mem_wr_t          wr_q;

    assign nxt_slot       = ~wr_slot;
    assign offset_full    = (offset_q == LEN_W'(SLOT_BYTES));
    assign full_after_rel = slot_full & ~slot_release;

    assign rx.mem_csb0  = csb_q;
    assign rx.mem_web0  = csb_q;
    assign rx.mem_addr0 = wr_q.addr;
    assign rx.mem_din0  = wr_q.data;

    always_ff @(posedge RX_CLK) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // A frame starting in the COMMIT cycle is handled as an IDLE entry into the freshly selected slot
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx.rx_data_v) state_d = slot_full[wr_slot] ? ST_DISCARD : ST_WRITE;
            end
            ST_WRITE: begin
                if (rx.rx_data_v) begin
                    if (offset_full) state_d = ST_DISCARD;
                end else begin
                    state_d = err_seen ? ST_IDLE : ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (rx.rx_data_v) state_d = full_after_rel[nxt_slot] ? ST_DISCARD : ST_WRITE;
                else              state_d = ST_IDLE;
            end
            ST_DISCARD: begin
                if (!rx.rx_data_v) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = '0;
        offset_d = offset_q;
        commit   = 1'b0;
        drop     = 1'b0;
        err_d    = (state_d == ST_IDLE) ? 1'b0 : (err_seen | (rx.rx_data_v & rx.rx_frame_err));
        unique case (state_q)
            ST_IDLE: begin
                if (rx.rx_data_v && !slot_full[wr_slot]) begin
                    wr_en    = 1'b1;
                    wr_addr  = {wr_slot, SLOT_W'(0)};
                    offset_d = LEN_W'(1);
                end
            end
            ST_WRITE: begin
                if (rx.rx_data_v && !offset_full) begin
                    wr_en    = 1'b1;
                    wr_addr  = {wr_slot, offset_q[SLOT_W-1:0]};
                    offset_d = offset_q + LEN_W'(1);
                end
                if (!rx.rx_data_v && err_seen) drop = 1'b1;
            end
            ST_COMMIT: begin
                commit = 1'b1;
                if (rx.rx_data_v && !full_after_rel[nxt_slot]) begin
                    wr_en    = 1'b1;
                    wr_addr  = {nxt_slot, SLOT_W'(0)};
                    offset_d = LEN_W'(1);
                end
            end
            ST_DISCARD: begin
                if (!rx.rx_data_v) drop = 1'b1;
            end
            default: ;
        endcase
    end

    // Release and commit may land in the same cycle; head follows commit order
    always_comb begin
        full_d = full_after_rel;
        head_d = head_slot;
        if (slot_release[head_slot] && slot_full[head_slot]) head_d = ~head_slot;
        if (commit) begin
            full_d[wr_slot] = 1'b1;
            if (full_after_rel == 2'b00) head_d = wr_slot;
        end
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            wr_slot   <= 1'b0;
            offset_q  <= '0;
            err_seen  <= 1'b0;
            slot_full <= 2'b00;
            slot_len0 <= '0;
            slot_len1 <= '0;
            head_slot <= 1'b0;
            frame_irq <= 1'b0;
            csb_q     <= 1'b1;
            wr_q      <= '0;
        end else begin
            offset_q  <= offset_d;
            err_seen  <= err_d;
            slot_full <= full_d;
            head_slot <= head_d;
            frame_irq <= commit;
            csb_q     <= ~wr_en;
            if (wr_en) begin
                wr_q.addr <= wr_addr;
                wr_q.data <= rx.rx_data;
            end
            if (commit) begin
                wr_slot <= nxt_slot;
                if (wr_slot) slot_len1 <= offset_q;
                else         slot_len0 <= offset_q;
            end
        end
    end

`ifdef RX_BUF_DROP_CNT_EN
    // Saturating count of dropped frames
    always_ff @(posedge RX_CLK) begin
        if (rst)                          drop_cnt <= 16'h0000;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_rx_buf_ctrl.sv
// Scoreboard bench for rx_buf_ctrl; also covers drop_cnt when RX_BUF_DROP_CNT_EN is defined.
module tb_rx_buf_ctrl;
    import vthernet_pkg::*;

    logic             RX_CLK = 1'b0;
    logic             rst;
    logic [1:0]       slot_release;
    logic [1:0]       slot_full;
    logic [LEN_W-1:0] slot_len0;
    logic [LEN_W-1:0] slot_len1;
    logic             head_slot;
    logic             frame_irq;
`ifdef RX_BUF_DROP_CNT_EN
    logic [15:0]      drop_cnt;
    int               m_drop;
`endif

    int      checks = 0;
    int      errors = 0;
    int      irq_cnt = 0;
    logic    irq_prev = 1'b0;
    mem_wr_t sb[$];
    mem_wr_t mon_e;

    logic [1:0] m_full;
    logic       m_wr;
    logic       m_head;
    int         m_len0, m_len1, m_commits;

    always #5 RX_CLK = ~RX_CLK;

    rx_buf_ctrl_if bus ();

    rx_buf_ctrl dut (
        .RX_CLK       (RX_CLK),
        .rst          (rst),
        .rx           (bus.slave),
        .slot_release (slot_release),
        .slot_full    (slot_full),
        .slot_len0    (slot_len0),
        .slot_len1    (slot_len1),
        .head_slot    (head_slot),
        .frame_irq    (frame_irq)
`ifdef RX_BUF_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every SRAM write must match the oldest pending expectation
    always @(negedge RX_CLK) begin
        if (bus.mem_csb0 === 1'b0) begin
            chk("web_with_csb", 32'(bus.mem_web0), 32'd0);
            if (sb.size() == 0) begin
                chk("wr_unexpected", 32'(bus.mem_addr0), 32'hFFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(bus.mem_addr0), 32'(mon_e.addr));
                chk("wr_data", 32'(bus.mem_din0), 32'(mon_e.data));
            end
        end
        if (frame_irq === 1'b1) begin
            irq_cnt++;
            if (irq_prev) chk("irq_one_cycle", 32'd1, 32'd0);
        end
        irq_prev = frame_irq;
    end

    task automatic model_reset();
        m_full = 2'b00; m_wr = 1'b0; m_head = 1'b0; m_len0 = 0; m_len1 = 0;
`ifdef RX_BUF_DROP_CNT_EN
        m_drop = 0;
`endif
    endtask

    task automatic model_drop();
`ifdef RX_BUF_DROP_CNT_EN
        m_drop++;
`endif
    endtask

    task automatic model_release(input logic [1:0] mask);
        logic hrel;
        hrel = mask[m_head] && m_full[m_head];
        m_full = m_full & ~mask;
        if (hrel) m_head = ~m_head;
    endtask

    task automatic model_commit(input int len);
        if (m_full == 2'b00) m_head = m_wr;
        m_full[m_wr] = 1'b1;
        if (m_wr) m_len1 = len; else m_len0 = len;
        m_wr = ~m_wr;
        m_commits++;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_slot_full"}, 32'(slot_full), 32'(m_full));
        chk({tag, "_slot_len0"}, 32'(slot_len0), 32'(m_len0));
        chk({tag, "_slot_len1"}, 32'(slot_len1), 32'(m_len1));
        chk({tag, "_head_slot"}, 32'(head_slot), 32'(m_head));
        chk({tag, "_irq_count"}, 32'(irq_cnt), 32'(m_commits));
`ifdef RX_BUF_DROP_CNT_EN
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    task automatic push_wr(input logic slot, input int off, input logic [7:0] d);
        mem_wr_t e;
        e.addr = {slot, SLOT_W'(off)};
        e.data = d;
        sb.push_back(e);
    endtask

    // Sends one frame; rel is driven during the cycle in which a commit would happen
    task automatic send_frame(input int n, input int err_at, input logic [7:0] seed, input logic [1:0] rel);
        logic go;
        go = !m_full[m_wr];
        for (int i = 0; i < n; i++) begin
            @(negedge RX_CLK);
            bus.rx_data_v    = 1'b1;
            bus.rx_data      = seed + 8'(i);
            bus.rx_frame_err = (i == err_at);
            if (go && i < int'(SLOT_BYTES)) push_wr(m_wr, i, seed + 8'(i));
        end
        @(negedge RX_CLK);
        bus.rx_data_v    = 1'b0;
        bus.rx_frame_err = 1'b0;
        @(negedge RX_CLK);
        slot_release = rel;
        @(negedge RX_CLK);
        slot_release = 2'b00;
        repeat (3) @(negedge RX_CLK);
        model_release(rel);
        if (!go || n > int'(SLOT_BYTES) || (err_at >= 0 && err_at < n)) model_drop();
        else model_commit(n);
    endtask

    task automatic release_slots(input logic [1:0] mask);
        @(negedge RX_CLK);
        slot_release = mask;
        @(negedge RX_CLK);
        slot_release = 2'b00;
        model_release(mask);
        @(negedge RX_CLK);
    endtask

    task automatic do_reset();
        @(negedge RX_CLK);
        rst = 1'b1;
        @(negedge RX_CLK);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_csb0"}, 32'(bus.mem_csb0), 32'd1);
        chk({tag, "_web0"}, 32'(bus.mem_web0), 32'd1);
        chk({tag, "_addr0"}, 32'(bus.mem_addr0), 32'd0);
        chk({tag, "_din0"}, 32'(bus.mem_din0), 32'd0);
        chk({tag, "_slot_full"}, 32'(slot_full), 32'd0);
        chk({tag, "_slot_len0"}, 32'(slot_len0), 32'd0);
        chk({tag, "_head_slot"}, 32'(head_slot), 32'd0);
        chk({tag, "_frame_irq"}, 32'(frame_irq), 32'd0);
`ifdef RX_BUF_DROP_CNT_EN
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        slot_release = 2'b00;
        bus.rx_data_v = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_frame_err = 1'b0;
        m_commits = 0;
        model_reset();
        repeat (3) @(negedge RX_CLK);
        check_reset_outputs("reset");
        rst = 1'b0;

        // 64-byte frame into empty slots
        send_frame(64, -1, 8'h00, 2'b00);
        check_state("t1");

        // Two commits fill both slots, a third frame is dropped
        do_reset();
        send_frame(10, -1, 8'h80, 2'b00);
        send_frame(20, -1, 8'h90, 2'b00);
        send_frame(5, -1, 8'hA0, 2'b00);
        check_state("t2");

        // Release head slot, refill it, then release coinciding with a commit
        release_slots(2'b01);
        check_state("t5_rel");
        send_frame(8, -1, 8'h30, 2'b00);
        check_state("t5_refill");
        release_slots(2'b10);
        send_frame(12, -1, 8'h50, 2'b01);
        check_state("t5_same_cycle");

        // Slot overflow: 512 writes, then the frame is dropped
        do_reset();
        send_frame(513, -1, 8'h11, 2'b00);
        check_state("t3");

        // Errored frame is dropped and the slot is reused from offset 0
        send_frame(30, 15, 8'h22, 2'b00);
        check_state("t4_err");
        send_frame(16, -1, 8'h40, 2'b00);
        check_state("t4_reuse");

        // Reset in the middle of a frame; the tail becomes a new frame
        do_reset();
        for (int i = 0; i < 150; i++) begin
            @(negedge RX_CLK);
            if (i == 101) begin
                check_reset_outputs("t6");
                rst = 1'b0;
            end
            bus.rx_data_v = 1'b1;
            bus.rx_data   = 8'h60 + 8'(i);
            if (i == 100) begin
                rst = 1'b1;
                model_reset();
            end else if (i < 100) begin
                push_wr(1'b0, i, 8'h60 + 8'(i));
            end else begin
                push_wr(1'b0, i - 101, 8'h60 + 8'(i));
            end
        end
        @(negedge RX_CLK);
        bus.rx_data_v = 1'b0;
        repeat (5) @(negedge RX_CLK);
        model_commit(49);
        check_state("t6_tail");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
